// File: rtl/rr_channel_merger_if.sv
// Handshake bundle between NUM_CH producer channels, the round-robin merger and its consumer.
// The slave modport is the merger's view; the master modport is the surrounding environment's view.
interface rr_channel_merger_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 8
);
  localparam int unsigned SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i;
  logic [NUM_CH-1:0]            ch_valid_i;
  logic [NUM_CH-1:0]            ch_last_i;
  logic [NUM_CH-1:0]            ch_ready_o;
  logic [DATA_WIDTH-1:0]        out_data_o;
  logic [SEL_WIDTH-1:0]         out_sel_o;
  logic                         out_last_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic                         busy_o;

  modport slave (
    input  ch_data_i, ch_valid_i, ch_last_i, out_ready_i,
    output ch_ready_o, out_data_o, out_sel_o, out_last_o, out_valid_o, busy_o
  );

  modport master (
    output ch_data_i, ch_valid_i, ch_last_i, out_ready_i,
    input  ch_ready_o, out_data_o, out_sel_o, out_last_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/rr_channel_merger.sv
// Round-robin merger of NUM_CH valid/ready channels into one tagged stream.
// Multi-word bursts are kept atomic; a single output register decouples the consumer.
module rr_channel_merger #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 8
) (
  input logic               clk_i,
  input logic               arstn_i,
  rr_channel_merger_if.slave bus
);
  localparam int unsigned SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("rr_channel_merger: NUM_CH must be in 2..8");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0]   lock_q, lock_d;
  logic                   busy_q;

  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [SEL_WIDTH-1:0]   out_sel_q;
  logic                   out_last_q;

  logic                   load_en;
  logic                   grant_vld;
  logic [SEL_WIDTH-1:0]   grant_idx;
  logic                   grant_last;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic                   xfer;
  logic [NUM_CH-1:0]      ready_c;

  // Successor channel, wrapping at NUM_CH (also for non-power-of-2 counts).
  function automatic logic [SEL_WIDTH-1:0] next_ch(input logic [SEL_WIDTH-1:0] c);
    if (32'(c) == NUM_CH - 1) return '0;
    else                      return c + SEL_WIDTH'(1);
  endfunction

  assign load_en = !out_valid_q || bus.out_ready_i;

  // Grant selection: locked channel only, or first valid channel starting at ptr.
  always_comb begin
    int unsigned cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (state_q == LOCKED) begin
      grant_vld = bus.ch_valid_i[lock_q];
      grant_idx = lock_q;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cand = 32'(ptr_q) + k;
        if (cand >= NUM_CH) cand = cand - NUM_CH;
        if (!grant_vld && bus.ch_valid_i[SEL_WIDTH'(cand)]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_WIDTH'(cand);
        end
      end
    end
  end

  assign xfer       = grant_vld && load_en;
  assign grant_last = bus.ch_last_i[grant_idx];
  assign grant_data = bus.ch_data_i[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Ready is held low during reset so no word is consumed while the output is cleared.
  always_comb begin
    ready_c = '0;
    if (xfer && arstn_i) ready_c[grant_idx] = 1'b1;
  end

  // Arbitration state transitions.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (grant_last) begin
            ptr_d = next_ch(grant_idx);
          end else begin
            lock_d  = grant_idx;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (xfer && grant_last) begin
          ptr_d   = next_ch(lock_q);
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lock_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      busy_q  <= (state_d == LOCKED);
      if (load_en) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= grant_data;
          out_sel_q  <= grant_idx;
          out_last_q <= grant_last;
        end
      end
    end
  end

  assign bus.ch_ready_o  = ready_c;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_sel_o   = out_sel_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_rr_channel_merger.sv
// Bench for rr_channel_merger: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the round-robin / burst-lock rules.
module tb_rr_channel_merger;
  localparam int NCH = 8;
  localparam int DW  = 32;
  localparam int SW  = 3;

  logic clk;
  logic arstn;

  rr_channel_merger_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  rr_channel_merger #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state.
  int          m_ptr, m_lock, m_os;
  bit          m_locked, m_ov, m_ol;
  logic [31:0] m_od;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_locked = 0;
    m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
  endtask

  task automatic clear_inputs();
    bus.ch_valid_i = '0;
    bus.ch_last_i  = '0;
    bus.ch_data_i  = '0;
  endtask

  task automatic set_ch(input int k, input bit v, input bit l, input logic [31:0] d);
    bus.ch_valid_i[SW'(k)]   = v;
    bus.ch_last_i[SW'(k)]    = l;
    bus.ch_data_i[k*DW +: DW] = d;
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, advances the model, returns at next posedge+1.
  task automatic tick();
    int              g;
    bit              load;
    bit              lst;
    logic [NCH-1:0]  exp_rdy;
    #4;
    load = !m_ov || bus.out_ready_i;
    g = -1;
    if (load) begin
      if (m_locked) begin
        if (bus.ch_valid_i[SW'(m_lock)]) g = m_lock;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m_ptr + k) % NCH;
          if (g < 0 && bus.ch_valid_i[SW'(c)]) g = c;
        end
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[SW'(g)] = 1'b1;
    chk("ch_ready", 64'(bus.ch_ready_o), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid_o), 64'(m_ov));
    if (m_ov) begin
      chk("out_data", 64'(bus.out_data_o), 64'(m_od));
      chk("out_sel", 64'(bus.out_sel_o), 64'(m_os));
      chk("out_last", 64'(bus.out_last_o), 64'(m_ol));
    end
    chk("busy", 64'(bus.busy_o), 64'(m_locked));
    if (load) begin
      m_ov = (g >= 0);
      if (g >= 0) begin
        m_od = bus.ch_data_i[g*DW +: DW];
        m_os = g;
        m_ol = bus.ch_last_i[SW'(g)];
      end
    end
    if (g >= 0) begin
      lst = bus.ch_last_i[SW'(g)];
      if (m_locked) begin
        if (lst) begin
          m_locked = 0;
          m_ptr = (m_lock + 1) % NCH;
        end
      end else if (lst) begin
        m_ptr = (g + 1) % NCH;
      end else begin
        m_locked = 1;
        m_lock = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    arstn = 1'b0;
    bus.out_ready_i = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_data", 64'(bus.out_data_o), 64'd0);
    arstn = 1'b1;

    // Round robin over all channels, single-word bursts.
    for (int k = 0; k < NCH; k++) set_ch(k, 1, 1, 32'h1000_0000 + 32'(k));
    for (int i = 0; i <= NCH; i++) begin
      tick();
      chk("rr_sel", 64'(bus.out_sel_o), 64'(i % NCH));
      chk("rr_data", 64'(bus.out_data_o), 64'(32'h1000_0000 + 32'(i % NCH)));
    end

    // Burst lock on ch2 while ch5 waits.
    clear_inputs();
    set_ch(2, 1, 0, 32'hA0);
    set_ch(5, 1, 1, 32'h55);
    tick();
    chk("lock_sel0", 64'(bus.out_sel_o), 64'd2);
    chk("lock_busy0", 64'(bus.busy_o), 64'd1);
    set_ch(2, 1, 0, 32'hA1);
    #1 chk("lock_rdy5a", 64'(bus.ch_ready_o[5]), 64'd0);
    tick();
    chk("lock_data1", 64'(bus.out_data_o), 64'hA1);
    chk("lock_busy1", 64'(bus.busy_o), 64'd1);
    set_ch(2, 1, 1, 32'hA2);
    #1 chk("lock_rdy5b", 64'(bus.ch_ready_o[5]), 64'd0);
    tick();
    chk("lock_data2", 64'(bus.out_data_o), 64'hA2);
    chk("lock_busy2", 64'(bus.busy_o), 64'd0);
    set_ch(2, 0, 0, 32'h0);
    tick();
    chk("lock_sel3", 64'(bus.out_sel_o), 64'd5);

    // Backpressure: output held, nothing accepted.
    clear_inputs();
    set_ch(1, 1, 1, 32'hBEEF_0001);
    tick();
    chk("bp_sel", 64'(bus.out_sel_o), 64'd1);
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NCH; k++) set_ch(k, 1'($urandom_range(0, 1)), 1, $urandom);
      #1 chk("bp_rdy", 64'(bus.ch_ready_o), 64'd0);
      tick();
      chk("bp_data", 64'(bus.out_data_o), 64'hBEEF_0001);
    end
    bus.out_ready_i = 1'b1;
    clear_inputs();
    tick();
    chk("bp_drain", 64'(bus.out_valid_o), 64'd0);

    // Wrap from ch7 to ch0.
    set_ch(6, 1, 1, 32'h66);
    tick();
    chk("wrap_sel6", 64'(bus.out_sel_o), 64'd6);
    clear_inputs();
    set_ch(0, 1, 1, 32'h00);
    set_ch(7, 1, 1, 32'h77);
    tick();
    chk("wrap_sel7", 64'(bus.out_sel_o), 64'd7);
    tick();
    chk("wrap_sel0", 64'(bus.out_sel_o), 64'd0);

    // Locked gap: ch3 drops valid mid-burst, ch4 must wait.
    clear_inputs();
    set_ch(3, 1, 0, 32'hC0);
    set_ch(4, 1, 1, 32'hD4);
    tick();
    chk("gap_sel", 64'(bus.out_sel_o), 64'd3);
    set_ch(3, 0, 0, 32'h0);
    tick();
    chk("gap_bubble1", 64'(bus.out_valid_o), 64'd0);
    tick();
    chk("gap_bubble2", 64'(bus.out_valid_o), 64'd0);
    set_ch(3, 1, 1, 32'hC1);
    tick();
    chk("gap_last", 64'(bus.out_data_o), 64'hC1);
    set_ch(3, 0, 0, 32'h0);
    tick();
    chk("gap_sel4", 64'(bus.out_sel_o), 64'd4);

    // Reset in the middle of a ch3 burst.
    clear_inputs();
    set_ch(3, 1, 0, 32'hE0);
    tick();
    chk("rb_busy", 64'(bus.busy_o), 64'd1);
    set_ch(0, 1, 1, 32'hF0);
    arstn = 1'b0;
    #1;
    chk("rb_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rb_data", 64'(bus.out_data_o), 64'd0);
    chk("rb_sel", 64'(bus.out_sel_o), 64'd0);
    chk("rb_last", 64'(bus.out_last_o), 64'd0);
    chk("rb_busy0", 64'(bus.busy_o), 64'd0);
    chk("rb_rdy", 64'(bus.ch_ready_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    arstn = 1'b1;
    tick();
    chk("rb_first", 64'(bus.out_sel_o), 64'd0);
    chk("rb_first_data", 64'(bus.out_data_o), 64'hF0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NCH; k++)
        set_ch(k, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
